otp_stream_dec: RTL and testbench



---
 rtl/otp_pkg.sv | 18 +
 rtl/otp_keystream_gen.sv | 40 ++++
 rtl/otp_stream_dec.sv | 110 +++++++++++
 tb/tb_otp_stream_dec.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// Shared definitions for the one-time-pad encoder/decoder pair.
package otp_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] LFSR_ALL_ONES = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXHAUSTED
    } otp_dec_state_t;

    // One left-shift step of the team LFSR; the encoder uses the same step.
    function automatic logic [BYTE_W-1:0] lfsr_step(input logic [BYTE_W-1:0] s);
        return {s[6:0], s[7] ^ s[6]};
    endfunction

endpackage

// File: rtl/otp_keystream_gen.sv
// Keystream generator: 8-bit LFSR with seed load and multi-step advance.
// A zero seed is replaced by all-ones so the LFSR never locks at zero.
module otp_keystream_gen
    import otp_pkg::*;
#(
    parameter int unsigned STEPS_PER_BYTE = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic [BYTE_W-1:0] seed,
    input  logic              advance,
    output logic [BYTE_W-1:0] key
);

    logic [BYTE_W-1:0] lfsr_q;
    logic [BYTE_W-1:0] lfsr_adv;

    // Unroll all steps for one consumed byte into a single cycle.
    always_comb begin
        lfsr_adv = lfsr_q;
        for (int unsigned i = 0; i < STEPS_PER_BYTE; i++) begin
            lfsr_adv = lfsr_step(lfsr_adv);
        end
    end

    // LFSR register: clear, then seed load, then advance on each consumed byte.
    always_ff @(posedge clk) begin
        if (clear) begin
            lfsr_q <= LFSR_ALL_ONES;
        end else if (load) begin
            lfsr_q <= (seed == '0) ? LFSR_ALL_ONES : seed;
        end else if (advance) begin
            lfsr_q <= lfsr_adv;
        end
    end

    assign key = lfsr_q;

endmodule

// File: rtl/otp_stream_dec.sv
// Byte-stream one-time-pad decoder with single-use pad enforcement.
// Optional parity tracking is enabled by defining OTP_DEC_PARITY_EN.
module otp_stream_dec
    import otp_pkg::*;
#(
    parameter  int unsigned STEPS_PER_BYTE = 8,
    parameter  int unsigned MAX_BYTES      = 256,
    localparam int unsigned CNT_W          = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              seed_load,
    input  logic [BYTE_W-1:0] seed,
    input  logic              ct_valid,
    output logic              ct_ready,
    input  logic [BYTE_W-1:0] ct_data,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic [BYTE_W-1:0] pt_data,
    output logic              exhausted,
    output logic [CNT_W-1:0]  byte_cnt
`ifdef OTP_DEC_PARITY_EN
    ,
    input  logic              ct_par,
    output logic              pt_perr,
    output logic              perr_sticky
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    otp_dec_state_t    state_q;
    logic [BYTE_W-1:0] key;
    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;

    otp_keystream_gen #(
        .STEPS_PER_BYTE (STEPS_PER_BYTE)
    ) u_keystream (
        .clk     (clk),
        .clear   (clear),
        .load    (seed_load),
        .seed    (seed),
        .advance (accept),
        .key     (key)
    );

    // Accept only in RUN with a free (or draining) output slot; a seed load
    // blocks the handshake so no byte straddles the old and new pad.
    always_comb begin
        ct_ready = (state_q == RUN) && !seed_load && !clear && (!pt_valid || pt_ready);
        accept   = ct_valid && ct_ready;
        cnt_inc  = byte_cnt + CNT_W'(1);
    end

    // FSM, byte counter and one-entry output register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= IDLE;
            pt_valid  <= 1'b0;
            pt_data   <= '0;
            byte_cnt  <= '0;
            exhausted <= 1'b0;
        end else begin
            if (accept) begin
                pt_data  <= ct_data ^ key;
                pt_valid <= 1'b1;
                byte_cnt <= cnt_inc;
                if (cnt_inc == MAX_CNT) begin
                    state_q   <= EXHAUSTED;
                    exhausted <= 1'b1;
                end
            end else if (pt_ready) begin
                pt_valid <= 1'b0;
            end
            // A pending output byte is kept; only the pad restarts.
            if (seed_load) begin
                state_q   <= RUN;
                byte_cnt  <= '0;
                exhausted <= 1'b0;
            end
        end
    end

`ifdef OTP_DEC_PARITY_EN
    logic par_err;
    assign par_err = ^{ct_data, ct_par};

    // Parity flag travels with the byte; sticky flag spans the whole pad.
    always_ff @(posedge clk) begin
        if (clear) begin
            pt_perr     <= 1'b0;
            perr_sticky <= 1'b0;
        end else begin
            if (accept) begin
                pt_perr <= par_err;
                if (par_err) begin
                    perr_sticky <= 1'b1;
                end
            end
            if (seed_load) begin
                perr_sticky <= 1'b0;
            end
        end
    end
`else
    // Without parity the decoder is a pure keystream XOR.
`endif

endmodule

// File: tb/tb_otp_stream_dec.sv
// Self-checking bench for otp_stream_dec (MAX_BYTES=4, STEPS_PER_BYTE=8).
module tb_otp_stream_dec;

    localparam int unsigned STEPS = 8;
    localparam int unsigned MAXB  = 4;
    localparam int unsigned CW    = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          clear;
    logic          seed_load;
    logic [7:0]    seed;
    logic          ct_valid;
    logic          ct_ready;
    logic [7:0]    ct_data;
    logic          pt_valid;
    logic          pt_ready;
    logic [7:0]    pt_data;
    logic          exhausted;
    logic [CW-1:0] byte_cnt;
`ifdef OTP_DEC_PARITY_EN
    logic          ct_par;
    logic          pt_perr;
    logic          perr_sticky;
`endif

    always #5 clk = ~clk;

    otp_stream_dec #(
        .STEPS_PER_BYTE (STEPS),
        .MAX_BYTES      (MAXB)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .seed_load   (seed_load),
        .seed        (seed),
        .ct_valid    (ct_valid),
        .ct_ready    (ct_ready),
        .ct_data     (ct_data),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .pt_data     (pt_data),
        .exhausted   (exhausted),
        .byte_cnt    (byte_cnt)
`ifdef OTP_DEC_PARITY_EN
        ,
        .ct_par      (ct_par),
        .pt_perr     (pt_perr),
        .perr_sticky (perr_sticky)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pad position counter plus the pending output byte.
    logic [7:0] m_seed   = 8'hFF;
    int         m_cnt    = 0;
    bit         m_loaded = 1'b0;
    bit         m_pv     = 1'b0;
    logic [7:0] m_pd     = 8'h00;
    bit         m_perr   = 1'b0;
    bit         m_sticky = 1'b0;

    // Key byte n of the pad started by seed sd: n*STEPS single steps in.
    function automatic logic [7:0] key_for(input logic [7:0] sd, input int n);
        int s;
        s = (sd == 8'h00) ? 255 : int'(sd);
        for (int i = 0; i < n * int'(STEPS); i++) begin
            s = ((s * 2) % 256) + (((s / 128) % 2) ^ ((s / 64) % 2));
        end
        return 8'(s);
    endfunction

    function automatic bit exp_ready();
        return m_loaded && (m_cnt < int'(MAXB)) && !seed_load && !clear && (!m_pv || pt_ready);
    endfunction

    task automatic drive(input bit sl, input logic [7:0] sd, input bit cv, input logic [7:0] cd,
                         input bit pr, input bit badp = 1'b0);
        seed_load = sl;
        seed      = sd;
        ct_valid  = cv;
        ct_data   = cd;
        pt_ready  = pr;
`ifdef OTP_DEC_PARITY_EN
        ct_par    = (^cd) ^ badp;
`else
        if (badp) ct_data = cd;
`endif
        #1;
    endtask

    // Advance DUT and model by one clock; returns 1ns after the edge.
    task automatic cycle();
        bit acc;
        bit perr;
        acc  = ct_valid && exp_ready();
`ifdef OTP_DEC_PARITY_EN
        perr = ^{ct_data, ct_par};
`else
        perr = 1'b0;
`endif
        @(posedge clk);
        if (clear) begin
            m_loaded = 1'b0; m_cnt = 0; m_pv = 1'b0; m_pd = 8'h00;
            m_perr = 1'b0; m_sticky = 1'b0;
        end else begin
            if (acc) begin
                m_pd = ct_data ^ key_for(m_seed, m_cnt);
                m_pv = 1'b1;
                m_cnt++;
                m_perr = perr;
                if (perr) m_sticky = 1'b1;
            end else if (pt_ready) begin
                m_pv = 1'b0;
            end
            if (seed_load) begin
                m_seed = seed; m_cnt = 0; m_loaded = 1'b1; m_sticky = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
        total++; if (ct_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_clear got=%b want=0", ct_ready); end
        cycle();
        total++; if (pt_valid !== 1'b0) begin bad++; $display("FAIL reset_pt_valid got=%b want=0", pt_valid); end
        total++; if (pt_data !== 8'h00) begin bad++; $display("FAIL reset_pt_data got=%h want=00", pt_data); end
        total++; if (byte_cnt !== CW'(0)) begin bad++; $display("FAIL reset_byte_cnt got=%0d want=0", byte_cnt); end
        total++; if (exhausted !== 1'b0) begin bad++; $display("FAIL reset_exhausted got=%b want=0", exhausted); end
        clear = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
        total++; if (ct_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b want=0", ct_ready); end
        cycle();
        total++; if (pt_valid !== 1'b0) begin bad++; $display("FAIL idle_no_accept got=%b want=0", pt_valid); end
    endtask

    task automatic test_basic();
        drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b1, 8'h41, 1'b1);
        total++; if (ct_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", ct_ready); end
        cycle();
        total++; if (pt_valid !== 1'b1) begin bad++; $display("FAIL basic_valid0 got=%b want=1", pt_valid); end
        total++; if (pt_data !== 8'h40) begin bad++; $display("FAIL basic_pt0 got=%h want=40", pt_data); end
        drive(1'b0, 8'h00, 1'b1, 8'h03, 1'b1);
        cycle();
        total++; if (pt_data !== 8'h00) begin bad++; $display("FAIL basic_pt1 got=%h want=00", pt_data); end
        total++; if (byte_cnt !== CW'(2)) begin bad++; $display("FAIL basic_cnt got=%0d want=2", byte_cnt); end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle();
        total++; if (pt_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", pt_valid); end
    endtask

    task automatic test_zero_seed();
        drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle();
        total++; if (byte_cnt !== CW'(0)) begin bad++; $display("FAIL zseed_cnt got=%0d want=0", byte_cnt); end
        drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1);
        cycle();
        total++; if (pt_data !== 8'h00) begin bad++; $display("FAIL zseed_pt got=%h want=00", pt_data); end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle();
    endtask

    task automatic test_exhaust();
        int acc = 0;
        drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        cycle();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'($urandom), 1'b1);
            total++; if (exhausted !== (i >= int'(MAXB))) begin bad++; $display("FAIL exh_flag_%0d got=%b want=%b", i, exhausted, (i >= int'(MAXB))); end
            if (ct_ready) acc++;
            cycle();
            total++; if (pt_data !== m_pd) begin bad++; $display("FAIL exh_pt_%0d got=%h want=%h", i, pt_data, m_pd); end
        end
        total++; if (acc != int'(MAXB)) begin bad++; $display("FAIL exh_accepts got=%0d want=%0d", acc, MAXB); end
        total++; if (ct_ready !== 1'b0) begin bad++; $display("FAIL exh_ready got=%b want=0", ct_ready); end
        total++; if (byte_cnt !== CW'(MAXB)) begin bad++; $display("FAIL exh_cnt got=%0d want=%0d", byte_cnt, MAXB); end
        drive(1'b1, 8'h33, 1'b1, 8'h00, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b1, 8'h11, 1'b1);
        total++; if (ct_ready !== 1'b1) begin bad++; $display("FAIL exh_reload_ready got=%b want=1", ct_ready); end
        total++; if (byte_cnt !== CW'(0)) begin bad++; $display("FAIL exh_reload_cnt got=%0d want=0", byte_cnt); end
        total++; if (exhausted !== 1'b0) begin bad++; $display("FAIL exh_reload_flag got=%b want=0", exhausted); end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle();
    endtask

    task automatic test_backpressure();
        logic [7:0] hold;
        logic [7:0] d;
        drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b1, 8'hA0, 1'b0);
        cycle();
        hold = 8'hA0 ^ key_for(8'h77, 0);
        total++; if (pt_data !== hold) begin bad++; $display("FAIL bp_first got=%h want=%h", pt_data, hold); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'($urandom), 1'b0);
            total++; if (ct_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_%0d got=%b want=0", i, ct_ready); end
            cycle();
            total++; if (pt_valid !== 1'b1 || pt_data !== hold) begin bad++; $display("FAIL bp_hold_%0d got=%b/%h want=1/%h", i, pt_valid, pt_data, hold); end
            total++; if (byte_cnt !== CW'(1)) begin bad++; $display("FAIL bp_cnt_%0d got=%0d want=1", i, byte_cnt); end
        end
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            drive(1'b0, 8'h00, 1'b1, d, 1'b1);
            total++; if (ct_ready !== 1'b1) begin bad++; $display("FAIL bp_resume_ready_%0d got=%b want=1", k, ct_ready); end
            cycle();
            total++; if (pt_valid !== 1'b1 || pt_data !== (d ^ key_for(8'h77, k + 1))) begin bad++; $display("FAIL bp_resume_%0d got=%h want=%h", k, pt_data, d ^ key_for(8'h77, k + 1)); end
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle();
    endtask

    task automatic test_seed_collision();
        logic [7:0] p;
        drive(1'b1, 8'h21, 1'b0, 8'h00, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b1, 8'h10, 1'b0);
        cycle();
        p = 8'h10 ^ key_for(8'h21, 0);
        drive(1'b1, 8'h9C, 1'b1, 8'h22, 1'b0);
        total++; if (ct_ready !== 1'b0) begin bad++; $display("FAIL coll_ready got=%b want=0", ct_ready); end
        cycle();
        total++; if (pt_valid !== 1'b1 || pt_data !== p) begin bad++; $display("FAIL coll_pending got=%b/%h want=1/%h", pt_valid, pt_data, p); end
        total++; if (byte_cnt !== CW'(0)) begin bad++; $display("FAIL coll_cnt got=%0d want=0", byte_cnt); end
        drive(1'b0, 8'h00, 1'b1, 8'h22, 1'b1);
        cycle();
        total++; if (pt_data !== (8'h22 ^ 8'h9C)) begin bad++; $display("FAIL coll_newkey got=%h want=%h", pt_data, 8'h22 ^ 8'h9C); end
        drive(1'b0, 8'h00, 1'b1, 8'h05, 1'b1);
        cycle();
        clear = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 8'h06, 1'b1);
        cycle();
        clear = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 8'h07, 1'b1);
        total++; if (pt_valid !== 1'b0) begin bad++; $display("FAIL midclr_valid got=%b want=0", pt_valid); end
        total++; if (ct_ready !== 1'b0) begin bad++; $display("FAIL midclr_ready got=%b want=0", ct_ready); end
        total++; if (byte_cnt !== CW'(0)) begin bad++; $display("FAIL midclr_cnt got=%0d want=0", byte_cnt); end
        cycle();
    endtask

`ifdef OTP_DEC_PARITY_EN
    task automatic test_parity();
        drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 1'b1);
        cycle();
        total++; if (pt_perr !== 1'b1 || perr_sticky !== 1'b1) begin bad++; $display("FAIL par_err got=%b/%b want=1/1", pt_perr, perr_sticky); end
        total++; if (pt_data !== 8'h40) begin bad++; $display("FAIL par_pt0 got=%h want=40", pt_data); end
        drive(1'b0, 8'h00, 1'b1, 8'h03, 1'b1);
        cycle();
        total++; if (pt_data !== 8'h00 || pt_perr !== 1'b0) begin bad++; $display("FAIL par_next got=%h/%b want=00/0", pt_data, pt_perr); end
        total++; if (perr_sticky !== 1'b1) begin bad++; $display("FAIL par_sticky got=%b want=1", perr_sticky); end
        drive(1'b1, 8'h44, 1'b0, 8'h00, 1'b1);
        cycle();
        total++; if (perr_sticky !== 1'b0) begin bad++; $display("FAIL par_sticky_clr got=%b want=0", perr_sticky); end
    endtask
`endif

    task automatic test_random();
        bit exp_r;
        for (int i = 0; i < 400; i++) begin
            clear = ($urandom_range(0, 60) == 0);
            drive(($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
                  8'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
            exp_r = exp_ready();
            total++; if (ct_ready !== exp_r) begin bad++; $display("FAIL rnd_ready_%0d got=%b want=%b", i, ct_ready, exp_r); end
            cycle();
            total++; if (pt_valid !== m_pv || pt_data !== m_pd) begin bad++; $display("FAIL rnd_pt_%0d got=%b/%h want=%b/%h", i, pt_valid, pt_data, m_pv, m_pd); end
            total++; if (byte_cnt !== CW'(m_cnt) || exhausted !== (m_loaded && m_cnt == int'(MAXB))) begin bad++; $display("FAIL rnd_cnt_%0d got=%0d/%b want=%0d/%b", i, byte_cnt, exhausted, m_cnt, (m_loaded && m_cnt == int'(MAXB))); end
`ifdef OTP_DEC_PARITY_EN
            total++; if (pt_perr !== m_perr || perr_sticky !== m_sticky) begin bad++; $display("FAIL rnd_par_%0d got=%b/%b want=%b/%b", i, pt_perr, perr_sticky, m_perr, m_sticky); end
`endif
        end
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        clear = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        test_reset();
        test_basic();
        test_zero_seed();
        test_exhaust();
        test_backpressure();
        test_seed_collision();
`ifdef OTP_DEC_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
